branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
Sequencer that owns one branch_unit comparator and resolves a single conditional branch at a time for the execute stage. It latches the operands, evaluates the compare against the front-end prediction and returns the resolved result over a valid/ready handshake. On a mispredict it issues a one-cycle redirect and holds a flush window. It also keeps saturating branch and mispredict counters for performance debug.

Parameters:
FLUSH_CYCLES, 2, length of the flush window after a mispredict; legal range is 1 or more.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  the only clock; all state changes on its rising edge.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  branch request valid.
in_ready  out  1  controller can accept a request.
in_pc  in  32  PC of the branch.
in_imm  in  32  sign-extended branch offset.
in_a  in  32  rs1 value.
in_b  in  32  rs2 value.
in_cmp_op  in  3  compare op: 000 beq, 001 bne, 010 blt, 011 bge, 100 bltu, 101 bgeu.
in_pred_taken  in  1  front-end prediction.
out_valid  out  1  resolved result valid.
out_ready  in  1  consumer accepts the result.
out_taken  out  1  resolved direction.
out_target  out  32  correct next PC.
out_mispredict  out  1  resolved direction differs from the prediction.
out_illegal  out  1  the cmp_op was 110 or 111.
redirect_valid  out  1  one-cycle fetch redirect pulse.
redirect_pc  out  32  redirect address.
flush  out  1  high during the flush window.
branch_cnt  out  CNT_W  count of legal branches retired.
mispredict_cnt  out  CNT_W  count of mispredicts retired.

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst).
- Reset values:
  - state is IDLE.
  - in_ready=1 in IDLE after reset.
  - out_valid, out_taken, out_mispredict, out_illegal, redirect_valid and flush are 0.
  - out_target and redirect_pc are 0.
  - Both counters are 0.
- Reset mid-operation discards any latched request. Nothing is emitted for it.
- FSM state IDLE:
  - in_ready=1; every other control output is 0.
  - On in_valid & in_ready at edge k: latch pc, imm, a, b, cmp_op and pred into registers, then go to EVAL.
- FSM state EVAL (exactly one cycle):
  - in_ready=0.
  - branch_unit is driven from the latched registers only.
  - Register the result at edge k+1 and go to RESP.
  - taken = branch_unit output for a legal op.
  - For illegal ops (110 or 111): taken=0, illegal=1, mispredict=0. The X from the comparator must never reach an output.
  - target = taken ? pc+imm : pc+4. Addition is modulo 2^32, so wrap-around is silent.
  - mispredict = legal & (taken != pred).
- FSM state RESP:
  - out_valid=1. All out_* values are stable until the handshake.
  - out_ready low: hold indefinitely.
  - On out_valid & out_ready:
    - Update the counters.
    - If mispredict, go to FLUSH. Otherwise go to IDLE, with in_ready=1 in the next cycle.
- FSM state FLUSH:
  - Lasts FLUSH_CYCLES cycles; flush=1 and in_ready=0 throughout.
  - redirect_valid=1 only in the first FLUSH cycle, with redirect_pc equal to the resolved target.
  - Go to IDLE after the last cycle.
- Throughput is at most one branch per 3 cycles. No request is accepted outside IDLE.
- Counters:
  - branch_cnt increments on a result handshake when illegal=0.
  - mispredict_cnt increments on a result handshake when mispredict=1.
  - Both saturate at all-ones; they never wrap.
- Compare semantics are those of branch_unit: blt/bge are two's-complement, bltu/bgeu are unsigned.

Decomposition:
- Shared package branch_pkg holds:
  - the CMP_BEQ..CMP_BGEU 3-bit constants;
  - the state enum (IDLE, EVAL, RESP, FLUSH);
  - an is_legal_cmp(op) function.
- One sub-module: a single instance of the existing branch_unit. Counters and FSM stay inline.

Test Plan:
- beq, a=b=5, pred=1, pc=0x100, imm=0x20 -> out_valid after edge k+1; taken=1, target=0x120, mispredict=0; no redirect; branch_cnt=1.
- blt, a=0xFFFFFFFF, b=1, pred=0, pc=0x200, imm=0x40 -> taken=1, mispredict=1. After the handshake: redirect_valid for 1 cycle with redirect_pc=0x240; flush high for exactly 2 cycles; in_ready=0 throughout; mispredict_cnt=1.
- bltu, same operands, pred=0, pc=0xFFFFFFFC, imm=8 -> taken=0, target=0x00000000 (wrap), no redirect.
- cmp_op=111 -> out_taken=0, out_illegal=1, mispredict=0; counters unchanged; no X on any output.
- out_ready held low for 5 cycles in RESP -> all out_* stable; in_ready=0; no counter change until the handshake.
- rst asserted during EVAL, and again in the 1st FLUSH cycle -> next cycle is IDLE with in_ready=1; outputs and counters 0; no out_valid or redirect afterwards.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: compare opcodes, controller states and opcode legality check
package branch_pkg;
    localparam logic [2:0] CMP_BEQ  = 3'b000;
    localparam logic [2:0] CMP_BNE  = 3'b001;
    localparam logic [2:0] CMP_BLT  = 3'b010;
    localparam logic [2:0] CMP_BGE  = 3'b011;
    localparam logic [2:0] CMP_BLTU = 3'b100;
    localparam logic [2:0] CMP_BGEU = 3'b101;

    typedef enum logic [1:0] {IDLE, EVAL, RESP, FLUSH} state_t;

    function automatic logic is_legal_cmp(input logic [2:0] op);
        return op <= CMP_BGEU;
    endfunction
endpackage

// File: rtl/branch_unit.sv
// branch_unit: combinational branch comparator; illegal ops report not-taken
module branch_unit
    import branch_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic        taken
);
    always_comb begin
        taken = 1'b0;
        case (op)
            CMP_BEQ:  taken = a == b;
            CMP_BNE:  taken = a != b;
            CMP_BLT:  taken = $signed(a) < $signed(b);
            CMP_BGE:  taken = $signed(a) >= $signed(b);
            CMP_BLTU: taken = a < b;
            CMP_BGEU: taken = a >= b;
            default:  taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: resolves one conditional branch at a time, issues
// redirect/flush on mispredict and keeps saturating performance counters
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [2:0]       in_cmp_op,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [31:0]      out_target,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    state_t      state, next;
    logic [31:0] pc_q, imm_q, a_q, b_q, target_q;
    logic [2:0]  op_q;
    logic        pred_q, taken_q, mis_q, ill_q;
    logic [FW-1:0] fcnt;
    logic        bu_taken, legal, taken_c, hs;
    logic [31:0] target_c;

    branch_unit u_bu (.a(a_q), .b(b_q), .op(op_q), .taken(bu_taken));

    // illegal ops are masked here so the comparator result never escapes
    assign legal    = is_legal_cmp(op_q);
    assign taken_c  = legal & bu_taken;
    assign target_c = taken_c ? pc_q + imm_q : pc_q + 32'd4;
    assign hs       = (state == RESP) && out_ready;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = in_valid ? EVAL : IDLE;
            EVAL:    next = RESP;
            RESP:    next = out_ready ? (mis_q ? FLUSH : IDLE) : RESP;
            FLUSH:   next = (fcnt == FW'(FLUSH_CYCLES - 1)) ? IDLE : FLUSH;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            {pc_q, imm_q, a_q, b_q, op_q, pred_q} <= '0;
            {taken_q, mis_q, ill_q, target_q}     <= '0;
            fcnt           <= '0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            state <= next;
            if (state == IDLE && in_valid) begin
                pc_q   <= in_pc;
                imm_q  <= in_imm;
                a_q    <= in_a;
                b_q    <= in_b;
                op_q   <= in_cmp_op;
                pred_q <= in_pred_taken;
            end
            if (state == EVAL) begin
                taken_q  <= taken_c;
                target_q <= target_c;
                mis_q    <= legal & (taken_c != pred_q);
                ill_q    <= ~legal;
            end
            fcnt <= (state == FLUSH) ? fcnt + FW'(1) : '0;
            if (hs && !ill_q && branch_cnt != '1)
                branch_cnt <= branch_cnt + CNT_W'(1);
            if (hs && mis_q && mispredict_cnt != '1)
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end

    assign in_ready       = state == IDLE;
    assign out_valid      = state == RESP;
    assign out_taken      = out_valid & taken_q;
    assign out_target     = out_valid ? target_q : '0;
    assign out_mispredict = out_valid & mis_q;
    assign out_illegal    = out_valid & ill_q;
    assign flush          = state == FLUSH;
    assign redirect_valid = flush && fcnt == '0;
    assign redirect_pc    = redirect_valid ? target_q : '0;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed plus randomized branches checked each
// cycle against a transaction-level reference of the resolve controller
module tb_branch_resolve_ctrl;
    localparam int FC   = 2;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_valid = 0, in_ready, in_pred_taken = 0, out_valid, out_ready = 0;
    logic [31:0]   in_pc = 0, in_imm = 0, in_a = 0, in_b = 0;
    logic [2:0]    in_cmp_op = 0;
    logic          out_taken, out_mispredict, out_illegal, redirect_valid, flush;
    logic [31:0]   out_target, redirect_pc;
    logic [CW-1:0] branch_cnt, mispredict_cnt;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_a(in_a), .in_b(in_b),
        .in_cmp_op(in_cmp_op), .in_pred_taken(in_pred_taken),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_target(out_target), .out_mispredict(out_mispredict),
        .out_illegal(out_illegal), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt)
    );

    typedef struct {
        logic        taken;
        logic        mis;
        logic        ill;
        logic [31:0] target;
    } res_t;

    int  ncmp = 0, nerr = 0;
    bit  chk_en = 0;
    logic        e_in_ready, e_out_valid, e_taken, e_mis, e_ill, e_redir, e_flush;
    logic [31:0] e_target, e_rpc;
    int          e_bcnt, e_mcnt;

    function automatic res_t ref_br(input logic [2:0] op, input logic [31:0] a, b, pc, imm,
                                    input logic pred);
        res_t r;
        logic c;
        case (op)
            3'd0: c = a == b;
            3'd1: c = a != b;
            3'd2: c = $signed(a) < $signed(b);
            3'd3: c = !($signed(a) < $signed(b));
            3'd4: c = a < b;
            3'd5: c = !(a < b);
            default: c = 1'b0;
        endcase
        r.ill    = op > 3'd5;
        r.taken  = !r.ill && c;
        r.target = r.taken ? pc + imm : pc + 32'd4;
        r.mis    = !r.ill && (r.taken != pred);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("no_x", 32'($isunknown({in_ready, out_valid, out_taken, out_target, out_mispredict,
                out_illegal, redirect_valid, redirect_pc, flush, branch_cnt, mispredict_cnt})), 0);
            chk("in_ready", 32'(in_ready), 32'(e_in_ready));
            chk("out_valid", 32'(out_valid), 32'(e_out_valid));
            chk("redirect_valid", 32'(redirect_valid), 32'(e_redir));
            chk("flush", 32'(flush), 32'(e_flush));
            chk("branch_cnt", 32'(branch_cnt), 32'(e_bcnt));
            chk("mispredict_cnt", 32'(mispredict_cnt), 32'(e_mcnt));
            if (e_out_valid) begin
                chk("out_taken", 32'(out_taken), 32'(e_taken));
                chk("out_target", out_target, e_target);
                chk("out_mispredict", 32'(out_mispredict), 32'(e_mis));
                chk("out_illegal", 32'(out_illegal), 32'(e_ill));
            end
            if (e_redir) chk("redirect_pc", redirect_pc, e_rpc);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp;
        e_in_ready = 1; e_out_valid = 0; e_redir = 0; e_flush = 0;
    endtask

    task automatic busy_exp;
        e_in_ready = 0; e_out_valid = 0; e_redir = 0; e_flush = 0;
    endtask

    // garbage on the request side while busy must never be accepted
    task automatic noise;
        in_valid  = 1'($urandom);
        in_a      = $urandom;
        in_b      = $urandom;
        in_pc     = $urandom;
        in_cmp_op = 3'($urandom);
    endtask

    task automatic do_reset;
        rst = 1; tick; rst = 0;
        in_valid = 0;
        e_bcnt = 0; e_mcnt = 0;
        idle_exp();
    endtask

    // rst_at: 0 none, 1 during EVAL, 2 in the first FLUSH cycle
    task automatic run_br(input logic [2:0] op, input logic [31:0] a, b, pc, imm,
                          input logic pred, input int dly, input int rst_at);
        res_t r;
        r = ref_br(op, a, b, pc, imm, pred);
        idle_exp();
        in_valid = 1; in_cmp_op = op; in_a = a; in_b = b; in_pc = pc; in_imm = imm;
        in_pred_taken = pred; out_ready = 1'($urandom);
        tick;
        busy_exp(); noise();
        if (rst_at == 1) begin
            do_reset();
            return;
        end
        tick;
        busy_exp();
        e_out_valid = 1; e_taken = r.taken; e_target = r.target; e_mis = r.mis; e_ill = r.ill;
        for (int i = 0; i < dly; i++) begin
            out_ready = 0; noise(); tick;
        end
        out_ready = 1; noise();
        tick;
        out_ready = 1'($urandom);
        if (!r.ill && e_bcnt < CMAX) e_bcnt++;
        if (r.mis && e_mcnt < CMAX) e_mcnt++;
        if (r.mis) begin
            for (int i = 0; i < FC; i++) begin
                busy_exp();
                e_flush = 1; e_redir = (i == 0); e_rpc = r.target;
                noise();
                if (rst_at == 2 && i == 0) begin
                    do_reset();
                    return;
                end
                tick;
            end
        end
        idle_exp();
        in_valid = 0;
    endtask

    initial begin
        res_t r;
        logic [2:0] op;
        logic [31:0] a, b;
        idle_exp();
        e_bcnt = 0; e_mcnt = 0;
        rst = 1;
        tick; tick;
        chk("rst_out_target", out_target, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst = 0;
        chk_en = 1;

        r = ref_br(3'd2, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, 0);
        chk("model_blt_taken", 32'(r.taken), 1);
        chk("model_blt_target", r.target, 32'h240);
        r = ref_br(3'd4, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 8, 0);
        chk("model_bltu_taken", 32'(r.taken), 0);
        chk("model_bltu_wrap", r.target, 32'h0000_0000);
        r = ref_br(3'd7, 3, 3, 32'h10, 32'h10, 1);
        chk("model_illegal", {29'd0, r.taken, r.ill, r.mis}, 32'b010);

        run_br(3'd0, 5, 5, 32'h100, 32'h20, 1, 0, 0);
        chk("beq_branch_cnt", 32'(branch_cnt), 1);
        run_br(3'd2, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, 0, 0, 0);
        chk("blt_mispredict_cnt", 32'(mispredict_cnt), 1);
        run_br(3'd4, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 8, 0, 0, 0);
        run_br(3'd7, 3, 3, 32'h10, 32'h10, 1, 0, 0);
        chk("illegal_branch_cnt", 32'(branch_cnt), 3);
        run_br(3'd1, 1, 2, 32'h300, 32'h8, 0, 5, 0);
        run_br(3'd3, 7, 9, 32'h400, 32'h8, 1, 0, 1);
        chk("rst_eval_cnt", 32'(branch_cnt), 0);
        run_br(3'd5, 9, 7, 32'h500, 32'h80, 0, 1, 2);
        chk("rst_flush_cnt", 32'(mispredict_cnt), 0);
        for (int g = 0; g < 3; g++) tick;

        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a = {1'($urandom), 31'($urandom_range(0, 3))};
                b = {1'($urandom), 31'($urandom_range(0, 3))};
            end
            run_br(op, a, b, $urandom, $urandom, 1'($urandom), $urandom_range(0, 3),
                   ($urandom_range(0, 29) == 0) ? $urandom_range(1, 2) : 0);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                out_ready = 1'($urandom);
                tick;
            end
        end
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
